// File: rtl/sound_latch_ctrl_pkg.sv
// Shared constants for the 68K-to-Z80 sound latch: default widths, banked
// window base and the pending-flag FSM encoding.
package sound_latch_ctrl_pkg;

    localparam int BANK_W_DEF = 5;
    localparam int WIN_W_DEF  = 14;

    localparam logic [15:0] BANKED_BASE = 16'hC000;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PENDING = 1'b1;

endpackage

// File: rtl/sound_latch_ctrl_rise_edge.sv
// One-bit rising-edge detector; history clears on reset so a strobe already
// high at release is reported on the first clock afterwards.
module rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic hist_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_p0 <= 1'b0;
        end else begin
            hist_p0 <= din;
        end
    end

    assign rise = din & ~hist_p0;

endmodule

// File: rtl/sound_latch_ctrl.sv
// Command latch, IRQ and ROM bank register linking the 68K main CPU to the
// Z80 sound CPU. Every chip-select is acted on once, at its rising edge.
module sound_latch_ctrl
    import sound_latch_ctrl_pkg::*;
#(
    parameter int BANK_W = BANK_W_DEF,
    parameter int WIN_W  = WIN_W_DEF,
    parameter int OVR_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m68k_latch_cs,
    input  logic [7:0]                m68k_dout,
    input  logic                      z80_latch_cs,
    input  logic                      z80_latch_clr_cs,
    input  logic                      z80_bank_set_cs,
    input  logic [7:0]                z80_dout,
    input  logic [15:0]               z80_addr,
    input  logic                      z80_m1_n,
    input  logic                      z80_iorq_n,
    output logic [7:0]                z80_latch_dout,
    output logic                      z80_irq_n,
    output logic [BANK_W-1:0]         z80_bank,
    output logic [BANK_W+WIN_W-1:0]   z80_banked_addr,
    output logic                      m68k_snd_pending,
    output logic [OVR_W-1:0]          overrun_cnt
);

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic wr_ev, clr_ev, bank_ev, ack_ev;
    logic state, state_nxt;
    logic ack_seen;

    rise_edge u_wr_edge   (.clk(clk), .reset(reset), .din(m68k_latch_cs),           .rise(wr_ev));
    rise_edge u_clr_edge  (.clk(clk), .reset(reset), .din(z80_latch_clr_cs),        .rise(clr_ev));
    rise_edge u_bank_edge (.clk(clk), .reset(reset), .din(z80_bank_set_cs),         .rise(bank_ev));
    rise_edge u_ack_edge  (.clk(clk), .reset(reset), .din(~z80_m1_n & ~z80_iorq_n), .rise(ack_ev));

    // A write event always wins over a clear arriving in the same clock.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (wr_ev) state_nxt = ST_PENDING;
            ST_PENDING: if (clr_ev && !wr_ev) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            z80_irq_n      <= 1'b1;
            z80_latch_dout <= 8'h00;
            overrun_cnt    <= '0;
            z80_bank       <= '0;
            ack_seen       <= 1'b0;
        end else begin
            state     <= state_nxt;
            z80_irq_n <= (state != ST_PENDING);
            if (wr_ev) begin
                z80_latch_dout <= m68k_dout;
                if (state == ST_PENDING) overrun_cnt <= sat_inc(overrun_cnt);
            end
            if (bank_ev) z80_bank <= z80_dout[BANK_W-1:0];
            // Interrupt ack is only observed; the IRQ stays level until cleared.
            if (clr_ev)      ack_seen <= 1'b0;
            else if (ack_ev) ack_seen <= 1'b1;
        end
    end

    // z80_latch_cs is a plain read: the byte is always presented, no side effects.
    assign m68k_snd_pending = (state == ST_PENDING);
    assign z80_banked_addr  = {z80_bank, z80_addr[WIN_W-1:0]};

endmodule

// File: tb/tb_sound_latch_ctrl.sv
// Directed table and sequence checks for sound_latch_ctrl.
module tb_sound_latch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        m68k_latch_cs, z80_latch_cs, z80_latch_clr_cs, z80_bank_set_cs;
    logic [7:0]  m68k_dout, z80_dout;
    logic [15:0] z80_addr;
    logic        z80_m1_n, z80_iorq_n;
    logic [7:0]  z80_latch_dout;
    logic        z80_irq_n;
    logic [4:0]  z80_bank;
    logic [18:0] z80_banked_addr;
    logic        m68k_snd_pending;
    logic [7:0]  overrun_cnt;

    int n_vec = 0;
    int n_bad = 0;

    sound_latch_ctrl dut (
        .clk(clk), .reset(reset),
        .m68k_latch_cs(m68k_latch_cs), .m68k_dout(m68k_dout),
        .z80_latch_cs(z80_latch_cs), .z80_latch_clr_cs(z80_latch_clr_cs),
        .z80_bank_set_cs(z80_bank_set_cs), .z80_dout(z80_dout),
        .z80_addr(z80_addr), .z80_m1_n(z80_m1_n), .z80_iorq_n(z80_iorq_n),
        .z80_latch_dout(z80_latch_dout), .z80_irq_n(z80_irq_n),
        .z80_bank(z80_bank), .z80_banked_addr(z80_banked_addr),
        .m68k_snd_pending(m68k_snd_pending), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, wcs, rcs, ccs, bcs, ack;
        logic [7:0]  wd, zd;
        logic [15:0] addr;
        logic [7:0]  e_dout;
        logic        e_irq_n, e_pend;
        logic [4:0]  e_bank;
        logic [7:0]  e_ovr;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic rst, input logic wcs, input logic [7:0] wd,
                                input logic rcs, input logic ccs, input logic bcs,
                                input logic [7:0] zd, input logic [15:0] addr, input logic ack,
                                input logic [7:0] e_dout, input logic e_irq_n, input logic e_pend,
                                input logic [4:0] e_bank, input logic [7:0] e_ovr);
        vec_t v;
        v.rst = rst; v.wcs = wcs; v.wd = wd; v.rcs = rcs; v.ccs = ccs; v.bcs = bcs;
        v.zd = zd; v.addr = addr; v.ack = ack;
        v.e_dout = e_dout; v.e_irq_n = e_irq_n; v.e_pend = e_pend;
        v.e_bank = e_bank; v.e_ovr = e_ovr;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic wcs, input logic [7:0] wd,
                         input logic rcs, input logic ccs, input logic bcs,
                         input logic [7:0] zd, input logic [15:0] addr, input logic ack);
        reset = rst; m68k_latch_cs = wcs; m68k_dout = wd;
        z80_latch_cs = rcs; z80_latch_clr_cs = ccs; z80_bank_set_cs = bcs;
        z80_dout = zd; z80_addr = addr; z80_m1_n = ~ack; z80_iorq_n = ~ack;
    endtask

    task automatic check(input string nm, input logic [7:0] e_dout, input logic e_irq_n,
                         input logic e_pend, input logic [4:0] e_bank, input logic [7:0] e_ovr);
        logic [18:0] e_baddr;
        e_baddr = {e_bank, z80_addr[13:0]};
        n_vec++;
        if (z80_latch_dout !== e_dout || z80_irq_n !== e_irq_n || m68k_snd_pending !== e_pend ||
            z80_bank !== e_bank || overrun_cnt !== e_ovr || z80_banked_addr !== e_baddr) begin
            n_bad++;
            $display("FAIL %s: got dout=%h irq_n=%b pend=%b bank=%h baddr=%h ovr=%h, want dout=%h irq_n=%b pend=%b bank=%h baddr=%h ovr=%h",
                     nm, z80_latch_dout, z80_irq_n, m68k_snd_pending, z80_bank, z80_banked_addr,
                     overrun_cnt, e_dout, e_irq_n, e_pend, e_bank, e_baddr, e_ovr);
        end
    endtask

    // One complete 68K write access: strobe high one clock, then low one clock.
    task automatic write_byte(input logic [7:0] b);
        drive(0, 1, b, 0, 0, 0, 8'h00, 16'h0000, 0);
        tick();
        drive(0, 0, b, 0, 0, 0, 8'h00, 16'h0000, 0);
        tick();
    endtask

    initial begin
        //            rst wcs wd     rcs ccs bcs zd     addr      ack  dout   irq pend bank   ovr
        tbl[0]  = mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 5'h00, 8'h00);
        tbl[1]  = mk(0, 1, 8'h5A, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 1, 1, 5'h00, 8'h00);
        tbl[2]  = mk(0, 1, 8'h5A, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[3]  = mk(0, 1, 8'h5A, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[4]  = mk(0, 1, 8'h5A, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[5]  = mk(0, 1, 8'h5A, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[6]  = mk(0, 1, 8'h5A, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[7]  = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[8]  = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[9]  = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[10] = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[11] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[12] = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 16'h0000, 1, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[13] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 1, 5'h00, 8'h00);
        tbl[14] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 16'h0000, 0, 8'h5A, 0, 0, 5'h00, 8'h00);
        tbl[15] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 16'h0000, 0, 8'h5A, 1, 0, 5'h00, 8'h00);
        tbl[16] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h5A, 1, 0, 5'h00, 8'h00);
        tbl[17] = mk(0, 0, 8'h00, 0, 0, 1, 8'hF3, 16'hC123, 0, 8'h5A, 1, 0, 5'h13, 8'h00);
        tbl[18] = mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 16'hC123, 0, 8'h5A, 1, 0, 5'h13, 8'h00);
        tbl[19] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'hFFFF, 0, 8'h5A, 1, 0, 5'h13, 8'h00);
        tbl[20] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'hC123, 1, 8'h5A, 1, 0, 5'h13, 8'h00);

        drive(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0);
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].wcs, tbl[i].wd, tbl[i].rcs, tbl[i].ccs, tbl[i].bcs,
                  tbl[i].zd, tbl[i].addr, tbl[i].ack);
            tick();
            check($sformatf("row%0d", i), tbl[i].e_dout, tbl[i].e_irq_n, tbl[i].e_pend,
                  tbl[i].e_bank, tbl[i].e_ovr);
        end

        // Back-to-back writes without a clear, then saturation.
        write_byte(8'h11);
        check("ovr_w1", 8'h11, 0, 1, 5'h13, 8'h00);
        write_byte(8'h22);
        check("ovr_w2", 8'h22, 0, 1, 5'h13, 8'h01);
        write_byte(8'h33);
        check("ovr_w3", 8'h33, 0, 1, 5'h13, 8'h02);
        for (int i = 0; i < 252; i++) write_byte(8'(i));
        check("ovr_fe", 8'hFB, 0, 1, 5'h13, 8'hFE);
        for (int i = 0; i < 48; i++) write_byte(8'h40 + 8'(i));
        check("ovr_sat", 8'h6F, 0, 1, 5'h13, 8'hFF);

        // Reset, then write and clear edges in the same clock.
        drive(1, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0);
        tick();
        check("rst2", 8'h00, 1, 0, 5'h00, 8'h00);
        write_byte(8'hAA);
        check("sim_pre", 8'hAA, 0, 1, 5'h00, 8'h00);
        drive(0, 1, 8'hBB, 0, 1, 0, 8'h00, 16'h0000, 0);
        tick();
        check("sim_same", 8'hBB, 0, 1, 5'h00, 8'h01);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0);
        tick();
        check("sim_post", 8'hBB, 0, 1, 5'h00, 8'h01);

        // Reset while pending and while the write strobe is held high.
        drive(0, 1, 8'hC3, 0, 0, 0, 8'h00, 16'h0000, 0);
        tick();
        check("mid_wr", 8'hC3, 0, 1, 5'h00, 8'h02);
        drive(1, 1, 8'hC3, 0, 0, 0, 8'h00, 16'h0000, 0);
        tick();
        check("mid_rst", 8'h00, 1, 0, 5'h00, 8'h00);
        drive(0, 1, 8'hC3, 0, 0, 0, 8'h00, 16'h0000, 0);
        tick();
        check("rel_ev", 8'hC3, 1, 1, 5'h00, 8'h00);
        tick();
        check("rel_irq", 8'hC3, 0, 1, 5'h00, 8'h00);
        tick();
        tick();
        check("rel_hold", 8'hC3, 0, 1, 5'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sound_latch_ctrl.md
Name: sound_latch_ctrl

Overview:
- Links the M68K main CPU to the Z80 sound CPU. Sits directly downstream of the address decoder and consumes its strobes: `m68k_latch_cs`, `z80_latch_cs`, `z80_latch_clr_cs` and `z80_bank_set_cs`.
- Holds the 68K→Z80 command byte and drives the Z80 interrupt request until the sound CPU acknowledges it.
- Owns the Z80 ROM bank register and forms the banked ROM address for the 0xC000–0xFFFF window.

Parameters:
- BANK_W, 5, width of the Z80 bank register (latched from Z80 D[4:0]).
- WIN_W, 14, width of the banked window offset (16 KB window).
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock; all CS inputs are sampled on it.
- reset  in  1  synchronous, active-high reset.
- m68k_latch_cs  in  1  68K write strobe for the command latch; level, held for several clocks.
- m68k_dout  in  8  68K data bus, low byte.
- z80_latch_cs  in  1  Z80 I/O read strobe, level.
- z80_latch_clr_cs  in  1  Z80 I/O write strobe that clears the pending flag, level.
- z80_bank_set_cs  in  1  Z80 I/O write strobe for the bank register, level.
- z80_dout  in  8  Z80 data bus out.
- z80_addr  in  16  Z80 address bus.
- z80_m1_n  in  1  Z80 M1; low together with `z80_iorq_n` marks interrupt acknowledge.
- z80_iorq_n  in  1  Z80 IORQ.
- z80_latch_dout  out  8  command byte presented to the Z80 data mux.
- z80_irq_n  out  1  Z80 INT, active low.
- z80_bank  out  BANK_W  current bank register.
- z80_banked_addr  out  BANK_W+WIN_W  ROM address for the banked window.
- m68k_snd_pending  out  1  status flag: a command has not yet been cleared by the Z80.
- overrun_cnt  out  OVR_W  count of commands overwritten while still pending; saturating.

Behaviour:
- Edge detection: each CS input has a 1-flop history. An event is a rising edge (CS=1 now, 0 last clock). Exactly one action per access, however many clocks the strobe is held.
- Reset values:
  - `z80_latch_dout`, `z80_bank`, `overrun_cnt` = 0.
  - `z80_irq_n` = 1, `m68k_snd_pending` = 0.
  - Edge-history flops = 0, so a CS already high when reset releases produces an event on the first clock after release.
- 68K write event:
  - Latch `m68k_dout` into the command byte and set pending, both in the next clock.
  - If pending was already 1, increment `overrun_cnt` (saturates at 2^OVR_W−1).
- Latency: `z80_irq_n` falls one clock after pending is set, i.e. 2 clocks after the CS rising edge. It is a registered output, equal to !pending.
- Z80 read: `z80_latch_dout` is the registered command byte at all times, with no read side effects. A read does not clear pending, because the latch is read on every I/O read.
- Z80 clear event: pending ← 0 next clock; `z80_irq_n` returns high one clock later.
- Interrupt acknowledge: a rising edge of (!`z80_m1_n` & !`z80_iorq_n`) does not clear pending. IRQ is level and held until a clear event. The ack edge is decoded only to set an internal debug flag `ack_seen`, which is cleared by a clear event.
- Simultaneous 68K write event and Z80 clear event: the write wins. The byte is updated, pending stays 1, and the overrun counter increments if pending was 1.
- Bank set event: `z80_bank` ← `z80_dout[BANK_W-1:0]` next clock.
- Banked address: `z80_banked_addr` = {`z80_bank`, `z80_addr[WIN_W-1:0]`}, combinational from the registered bank. It is valid only while the decoder asserts the banked window.
- Reset mid-operation: synchronous reset overrides every event in the same clock. An IRQ that is pending is dropped (`z80_irq_n` = 1 on the next clock).
- State: one 2-state FSM, IDLE (pending=0) and PENDING (pending=1).
  - IDLE → PENDING on a write event.
  - PENDING → IDLE on a clear event with no write event.
  - PENDING → PENDING on a write event (counts overrun).
- Width rules: the overrun counter never wraps. Data bits above BANK_W are ignored.

Decomposition:
- Shared package: BANK_W and WIN_W defaults; `BANKED_BASE` = 16'hC000; the FSM state encoding (IDLE=1'b0, PENDING=1'b1).
- One sub-module `rise_edge` (1-bit synchronous rising-edge detector with synchronous reset), instantiated four times: write, clear, bank set and ack.

Test Plan:
1. Reset, then hold `m68k_latch_cs` high 6 clocks with `m68k_dout` = 8'h5A → `z80_latch_dout` = 8'h5A; pending = 1; `z80_irq_n` low exactly 2 clocks after the edge; `overrun_cnt` = 0 (single event).
2. Pending set, `z80_latch_cs` pulsed 3 times → byte stays 8'h5A and `z80_irq_n` stays low. Then `z80_latch_clr_cs` edge → pending 0 next clock, `z80_irq_n` high the clock after.
3. Write 8'h11, then 8'h22 with no clear, then a third write 8'h33 → `z80_latch_dout` = 8'h33, `overrun_cnt` = 2. Force 300 overruns → counter holds 8'hFF.
4. Write edge and clear edge in the same clock while pending = 1 → pending stays 1, byte updated, `overrun_cnt` increments by 1.
5. `z80_bank_set_cs` edge with `z80_dout` = 8'hF3 → `z80_bank` = 5'h13; `z80_addr` = 16'hC123 → `z80_banked_addr` = 19'h4C123.
6. Pending = 1 with IRQ low; assert reset 1 clock while `m68k_latch_cs` is held high → next clock: `z80_irq_n` = 1 and all outputs zero. After release with CS still high, one write event occurs.
